// File: rtl/seg7card_rx.sv
// ============================================================================
// Module      : seg7card_rx
// Description : Recovers a card code (1..13) from an asynchronous active-low
//               7-segment bus, debounces it and hands each new card over a
//               valid/ready interface. Optional macro SEG7CARD_ERR_EN enables
//               the card_err pulse for accepted illegal patterns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7card_rx #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       card_ready,
    output logic [3:0] card_out,
    output logic       card_valid,
    output logic       card_err,
    output logic       locked,
    output logic       overrun
);

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_SETTLE = 2'd1;
    localparam logic [1:0] C_HOLD   = 2'd2;
    localparam logic [6:0] C_BLANK  = 7'b1111111;
    localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

    logic [6:0] r_s1;
    logic [6:0] r_s2;
    logic [6:0] r_cand;
    logic [7:0] r_cnt;
    logic [1:0] r_state;
    logic [3:0] r_card_out;
    logic       r_card_valid;
    logic       r_locked;
    logic       r_overrun;
    logic       w_legal;
    logic [3:0] w_code;

    always_comb begin
        w_legal = 1'b1;
        w_code  = 4'd0;
        case (r_cand)
            7'b0001000: w_code = 4'd1;
            7'b0100100: w_code = 4'd2;
            7'b0110000: w_code = 4'd3;
            7'b0011001: w_code = 4'd4;
            7'b0010010: w_code = 4'd5;
            7'b0000010: w_code = 4'd6;
            7'b1111000: w_code = 4'd7;
            7'b0000000: w_code = 4'd8;
            7'b0010000: w_code = 4'd9;
            7'b1000000: w_code = 4'd10;
            7'b1100001: w_code = 4'd11;
            7'b0011000: w_code = 4'd12;
            7'b0001001: w_code = 4'd13;
            default:    w_legal = 1'b0;
        endcase
    end

`ifdef SEG7CARD_ERR_EN
    logic r_card_err;
    logic w_blank;
    assign w_blank  = (r_cand == C_BLANK);
    assign card_err = r_card_err;
`else
    assign card_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1         <= C_BLANK;
            r_s2         <= C_BLANK;
            r_cand       <= C_BLANK;
            r_cnt        <= 8'd0;
            r_state      <= C_IDLE;
            r_card_out   <= 4'd0;
            r_card_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SEG7CARD_ERR_EN
            r_card_err   <= 1'b0;
`endif
        end else begin
            r_s1 <= seg_in;
            r_s2 <= r_s1;
`ifdef SEG7CARD_ERR_EN
            r_card_err <= 1'b0;
`endif
            // Consumption first; an acceptance on the same edge overrides it.
            if (r_card_valid && card_ready) begin
                r_card_valid <= 1'b0;
            end
            case (r_state)
                C_IDLE, C_HOLD: begin
                    if (r_s2 != r_cand) begin
                        r_cand   <= r_s2;
                        r_cnt    <= 8'd1;
                        r_locked <= 1'b0;
                        r_state  <= C_SETTLE;
                    end
                end
                C_SETTLE: begin
                    if (r_s2 != r_cand) begin
                        r_cand   <= r_s2;
                        r_cnt    <= 8'd1;
                        r_locked <= 1'b0;
                    end else if (r_cnt == C_STABLE) begin
                        r_state <= C_HOLD;
                        if (w_legal) begin
                            r_card_out   <= w_code;
                            r_card_valid <= 1'b1;
                            r_locked     <= 1'b1;
                            if (r_card_valid && !card_ready) begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_locked <= 1'b0;
`ifdef SEG7CARD_ERR_EN
                            r_card_err <= !w_blank;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= C_IDLE;
            endcase
        end
    end

    assign card_out   = r_card_out;
    assign card_valid = r_card_valid;
    assign locked     = r_locked;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_seg7card_rx.sv
// ============================================================================
// Module      : tb_seg7card_rx
// Description : Scoreboard bench for seg7card_rx with directed segment vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7card_rx;

    logic       clk;
    logic       reset;
    logic [6:0] seg_in;
    logic       card_ready;
    logic [3:0] card_out;
    logic       card_valid;
    logic       card_err;
    logic       locked;
    logic       overrun;

    int         checks;
    int         errors;
    int         err_pulses;
    logic [3:0] exp_q[$];

    seg7card_rx #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .card_ready (card_ready),
        .card_out   (card_out),
        .card_valid (card_valid),
        .card_err   (card_err),
        .locked     (locked),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: every handshake transfer must match the next queued card.
    always @(negedge clk) begin
        if (!reset) begin
            if (card_err === 1'b1) err_pulses++;
            if (card_valid === 1'b1 && card_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_card: got %0d, expected none", card_out);
                end else begin
                    check("card_transfer", 32'(card_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic edges(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int err_before;

    initial begin
        checks = 0; errors = 0; err_pulses = 0;
        reset = 1'b1; seg_in = 7'b1111111; card_ready = 1'b1;
        edges(3);
        reset = 1'b0;
        check("rst_card_out", 32'(card_out), 0);
        check("rst_card_valid", 32'(card_valid), 0);
        check("rst_card_err", 32'(card_err), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_overrun", 32'(overrun), 0);

        // Card 2: valid after edge E+6 (STABLE_CYCLES + 2), one-cycle transfer.
        edges(1);
        exp_q.push_back(4'd2);
        seg_in = 7'b0100100;
        edges(6);
        check("t1_valid_early", 32'(card_valid), 0);
        edges(1);
        check("t1_valid", 32'(card_valid), 1);
        check("t1_card_out", 32'(card_out), 2);
        check("t1_locked", 32'(locked), 1);
        edges(1);
        check("t1_valid_fall", 32'(card_valid), 0);

        // King with a 2-cycle glitch to 8 mid-settle: only one card 13.
        edges(2);
        exp_q.push_back(4'd13);
        seg_in = 7'b0001001;
        edges(3);
        seg_in = 7'b0000000;
        edges(2);
        seg_in = 7'b0001001;
        edges(14);
        check("t2_queue_empty", 32'(exp_q.size()), 0);

        // Overrun: Ace pending, replaced by 10 while card_ready is low.
        card_ready = 1'b0;
        seg_in = 7'b0001000;
        edges(9);
        check("t3_valid_ace", 32'(card_valid), 1);
        check("t3_card_ace", 32'(card_out), 1);
        check("t3_no_overrun", 32'(overrun), 0);
        seg_in = 7'b1000000;
        edges(9);
        check("t3_card_ten", 32'(card_out), 10);
        check("t3_overrun", 32'(overrun), 1);
        exp_q.push_back(4'd10);
        card_ready = 1'b1;
        edges(1);
        check("t3_valid_fall", 32'(card_valid), 0);
        edges(3);
        check("t3_overrun_sticky", 32'(overrun), 1);

        // Illegal pattern.
        err_before = err_pulses;
        seg_in = 7'b0101010;
        edges(12);
`ifdef SEG7CARD_ERR_EN
        check("t4_err_pulses", 32'(err_pulses - err_before), 1);
`else
        check("t4_err_pulses", 32'(err_pulses - err_before), 0);
`endif
        check("t4_locked", 32'(locked), 0);
        check("t4_valid", 32'(card_valid), 0);

        // 3 -> blank -> 3: two separate cards.
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd3);
        seg_in = 7'b0110000;
        edges(8);
        check("t5_locked_first", 32'(locked), 1);
        edges(2);
        seg_in = 7'b1111111;
        edges(8);
        check("t5_locked_blank", 32'(locked), 0);
        edges(2);
        seg_in = 7'b0110000;
        edges(10);
        check("t5_locked_second", 32'(locked), 1);
        check("t5_queue_empty", 32'(exp_q.size()), 0);

        // Reset with a pending card: card is lost.
        card_ready = 1'b0;
        seg_in = 7'b0011001;
        edges(9);
        check("t6_valid_pending", 32'(card_valid), 1);
        reset = 1'b1;
        seg_in = 7'b1111111;
        edges(1);
        reset = 1'b0;
        check("t6_card_valid", 32'(card_valid), 0);
        check("t6_card_out", 32'(card_out), 0);
        check("t6_overrun", 32'(overrun), 0);
        check("t6_locked", 32'(locked), 0);
        card_ready = 1'b1;
        edges(10);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7card_rx.md
# seg7card_rx

Receiver that recovers a 4-bit card code from an active-low 7-segment pattern. It is the inverse of the card-to-display decoder. It accepts a 7-segment bus driven from another board or display source, synchronises and debounces it, and maps stable patterns back to card codes 1..13. Each new card is delivered once over a valid/ready handshake to the game logic.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronised cycles a pattern must hold before it is accepted. Legal range 1..255.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `seg_in`  in  7  active-low segment pattern. Bit 0 = a … bit 6 = g. Asynchronous to `clk`.
- `card_ready`  in  1  consumer accepts `card_out` this cycle.
- `card_out`  out  4  decoded card code: 1 = Ace, 2..10, 11 = J, 12 = Q, 13 = K.
- `card_valid`  out  1  `card_out` holds an unconsumed card.
- `card_err`  out  1  one-cycle pulse: an unrecognised pattern was accepted.
- `locked`  out  1  the currently accepted pattern is a legal card.
- `overrun`  out  1  sticky: a pending card was replaced before it was consumed.

## Operation
- Decode map (`seg_in` → code):
  - 1111111 → blank
  - 0001000 → 1
  - 0100100 → 2
  - 0110000 → 3
  - 0011001 → 4
  - 0010010 → 5
  - 0000010 → 6
  - 1111000 → 7
  - 0000000 → 8
  - 0010000 → 9
  - 1000000 → 10
  - 1100001 → 11
  - 0011000 → 12
  - 0001001 → 13
  - Any other pattern is illegal.
- Input path: 2-flop synchroniser `s1` → `s2`. Both flops reset to 1111111.
- Candidate register `cand` (reset 1111111) and 8-bit counter `cnt` (reset 0).
- FSM states:
  - IDLE, entered on reset:
    - `s2 != cand` → `cand <= s2`, `cnt <= 1`, go to SETTLE.
  - SETTLE:
    - `s2 != cand` → reload `cand`, `cnt <= 1`, stay in SETTLE.
    - Otherwise `cnt` increments.
    - When `cnt == STABLE_CYCLES` with `s2 == cand`, the pattern is accepted. Go to HOLD.
    - With `STABLE_CYCLES = 1`, acceptance happens on the cycle after the load.
  - HOLD:
    - `s2 == cand` → stay; no further output.
    - `s2 != cand` → `cand <= s2`, `cnt <= 1`, go to SETTLE.
- On acceptance:
  - Legal card: `card_out <= code`, `card_valid <= 1`, `locked <= 1`.
  - Blank: no card, `locked <= 0`.
  - Illegal: `card_err` pulses for 1 cycle, `locked <= 0`, `card_valid` unchanged.
  - `locked` falls to 0 on the cycle `cand` is reloaded.
- Handshake:
  - A transfer occurs when `card_valid && card_ready`. `card_valid` clears on the next edge unless a new card is accepted on that same edge.
  - `card_out` is stable while `card_valid && !card_ready`.
- Boundary cases:
  - New card accepted while a card is pending and `card_ready` is low: new card replaces the old one, `overrun <= 1`.
  - New card accepted in the same cycle as a transfer: new card loads, no overrun.
  - A repeated identical stable pattern never re-emits. The pattern must change and re-settle to re-emit, including the sequence X → blank → X.
  - `overrun` is cleared only by `reset`.

## Timing
- Reset values: `card_out` = 0, `card_valid` = 0, `card_err` = 0, `locked` = 0, `overrun` = 0, state = IDLE.
- Latency: with `seg_in` changed before edge E and held, `card_valid` is high after edge E + STABLE_CYCLES + 2. That is 6 edges for the default.
- Any glitch that reaches `s2` shorter than STABLE_CYCLES restarts settling. No output is produced from it.
- `reset` asserted mid-settle or while `card_valid` is high: every output returns to its reset value on that edge and the pending card is lost.
- `card_ready` has no effect while `card_valid` is 0.

## Configuration
- `SEG7CARD_ERR_EN`
  - Defined: illegal accepted patterns pulse `card_err` as described above.
  - Undefined: `card_err` is tied to 0. Illegal patterns are treated as blank: `locked <= 0`, no pulse, no card.

## Test plan
- Reset, then `seg_in` = 0100100 held, `card_ready` = 1:
  - `card_valid` rises 6 edges after the change with `card_out` = 2.
  - `card_valid` falls one cycle later.
  - `locked` = 1.
- `seg_in` = 0001001 with a 2-cycle glitch to 0000000 mid-settle (STABLE_CYCLES = 4):
  - No card from 0000000.
  - Exactly one card, `card_out` = 13, after 0001001 is held 4 synchronised cycles.
- `card_ready` = 0, apply Ace (0001000), then 1000000 after it settles:
  - `card_out` goes 1 then 10.
  - `overrun` = 1 and stays set until `reset`.
- Illegal pattern 0101010 held:
  - With `SEG7CARD_ERR_EN`: single `card_err` pulse, `locked` = 0, no `card_valid`.
  - Without it: `card_err` stays 0.
- Sequence 0110000 → 1111111 → 0110000, each held 10 cycles:
  - Two separate cards with code 3.
  - `locked` low during the blank interval.
- Assert `reset` while `card_valid` = 1 and `card_ready` = 0:
  - Next cycle `card_valid` = 0, `card_out` = 0, `overrun` = 0, `locked` = 0.
